imem_arbiter: RTL and testbench

// Shares the single instruction-memory port between the Beta fetch stage (CPU) and the

---
 rtl/imem_arbiter.sv | 152 +++++++++++++++
 tb/tb_imem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: shares one memory port between the CPU fetch stage
// and the program loader, with loader starvation protection and a loader lock mode.
module imem_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_ia,
    output logic          cpu_ready,
    output logic          cpu_valid,
    output logic [DW-1:0] cpu_id,
    output logic          cpu_stall,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic          ldr_hold,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ready,
    output logic          ldr_valid,
    output logic [DW-1:0] ldr_rdata,
    output logic [AW-1:0] mem_ia,
    output logic          mem_we,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_id
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          cpu_valid_q, cpu_valid_d;
    logic          ldr_valid_q, ldr_valid_d;
    logic [DW-1:0] cpu_id_q, cpu_id_d;
    logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
    logic          cpu_gnt_s, ldr_gnt_s;

    // The memory never sees the supervisor bit.
    function automatic logic [AW-1:0] strip_sup(input logic [AW-1:0] addr);
        strip_sup = {1'b0, addr[AW-2:0]};
    endfunction

    // Grant decision: CPU has priority in ARB unless the loader has waited too long.
    always_comb begin
        cpu_gnt_s = 1'b0;
        ldr_gnt_s = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (ldr_req && (!cpu_req || (starve_q == STARVE_TOP))) begin
                    ldr_gnt_s = 1'b1;
                end else begin
                    cpu_gnt_s = cpu_req;
                end
            end
            ST_LOCK: begin
                ldr_gnt_s = ldr_req;
            end
            default: begin
                cpu_gnt_s = 1'b0;
                ldr_gnt_s = 1'b0;
            end
        endcase
    end

    // Next-state for lock FSM; the cycle that drops hold still belongs to the loader.
    always_comb begin
        state_d = ST_ARB;
        case (state_q)
            ST_ARB: begin
                if (ldr_gnt_s && ldr_hold) begin
                    state_d = ST_LOCK;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_LOCK: begin
                if (ldr_hold) begin
                    state_d = ST_LOCK;
                end else begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Starvation counter and registered response next-state.
    always_comb begin
        starve_d    = {SW{1'b0}};
        cpu_valid_d = cpu_gnt_s;
        ldr_valid_d = ldr_gnt_s;
        cpu_id_d    = cpu_id_q;
        ldr_rdata_d = ldr_rdata_q;
        if (ldr_req && !ldr_gnt_s) begin
            if (starve_q == STARVE_TOP) begin
                starve_d = starve_q;
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end else begin
            starve_d = {SW{1'b0}};
        end
        if (cpu_gnt_s) begin
            cpu_id_d = mem_id;
        end else begin
            cpu_id_d = cpu_id_q;
        end
        // mem_id is read before the edge that commits a loader write, so rdata is pre-write.
        if (ldr_gnt_s) begin
            ldr_rdata_d = mem_id;
        end else begin
            ldr_rdata_d = ldr_rdata_q;
        end
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ARB;
            starve_q    <= {SW{1'b0}};
            cpu_valid_q <= 1'b0;
            ldr_valid_q <= 1'b0;
            cpu_id_q    <= {DW{1'b0}};
            ldr_rdata_q <= {DW{1'b0}};
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            cpu_valid_q <= cpu_valid_d;
            ldr_valid_q <= ldr_valid_d;
            cpu_id_q    <= cpu_id_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    assign cpu_ready = cpu_gnt_s;
    assign ldr_ready = ldr_gnt_s;
    assign cpu_stall = cpu_req & ~cpu_gnt_s;
    assign mem_ia    = ldr_gnt_s ? strip_sup(ldr_addr) : strip_sup(cpu_ia);
    assign mem_we    = ldr_gnt_s & ldr_we;
    assign mem_wd    = ldr_wdata;
    assign cpu_valid = cpu_valid_q;
    assign ldr_valid = ldr_valid_q;
    assign cpu_id    = cpu_id_q;
    assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: a 64-word memory behind the port and a transaction-level
// reference model predicting grants, addresses and responses each cycle.
module tb_imem_arbiter;

    localparam int SMAX = 4;

    logic        clk;
    logic        reset;
    logic        cpu_req, ldr_req, ldr_we, ldr_hold;
    logic [31:0] cpu_ia, ldr_addr, ldr_wdata;
    logic        cpu_ready, cpu_valid, cpu_stall, ldr_ready, ldr_valid, mem_we;
    logic [31:0] cpu_id, ldr_rdata, mem_ia, mem_wd, mem_id;

    logic [31:0] mem [0:63];

    int checks = 0;
    int fails  = 0;

    // reference model state
    bit          m_locked;
    int          m_wait;
    logic [3:0]  exp_comb, obs_comb;   // {cpu_ready, ldr_ready, cpu_stall, mem_we}
    logic [31:0] exp_ia, obs_ia, obs_wd;
    logic [1:0]  exp_out, obs_out;     // {cpu_valid, ldr_valid}
    logic [31:0] exp_cid, exp_lrd, obs_cid, obs_lrd;

    imem_arbiter #(.DW(32), .AW(32), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_ia(cpu_ia), .cpu_ready(cpu_ready), .cpu_valid(cpu_valid),
        .cpu_id(cpu_id), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_hold(ldr_hold), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_ready(ldr_ready), .ldr_valid(ldr_valid),
        .ldr_rdata(ldr_rdata),
        .mem_ia(mem_ia), .mem_we(mem_we), .mem_wd(mem_wd), .mem_id(mem_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_id = mem[mem_ia[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_ia[7:2]] <= mem_wd;

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {1'($urandom_range(0, 1)), 23'd0, 6'($urandom_range(0, 63)), 2'b00};
        return a;
    endfunction

    // One clock of stimulus; captures observed values and the model's predictions.
    task automatic tick(input logic r, input logic cr, input logic [31:0] cia,
                        input logic lr, input logic lwe, input logic lh,
                        input logic [31:0] la, input logic [31:0] lwd);
        bit gl, gc;
        logic [31:0] rd;
        reset = r; cpu_req = cr; cpu_ia = cia; ldr_req = lr; ldr_we = lwe;
        ldr_hold = lh; ldr_addr = la; ldr_wdata = lwd;
        #1;
        gl = lr && (m_locked || !cr || m_wait >= SMAX);
        gc = cr && !m_locked && !gl;
        exp_ia   = (gl ? la : cia) & 32'h7FFF_FFFF;
        exp_comb = {gc, gl, cr && !gc, gl && lwe};
        rd       = mem[exp_ia[7:2]];
        obs_comb = {cpu_ready, ldr_ready, cpu_stall, mem_we};
        obs_ia   = mem_ia;
        obs_wd   = mem_wd;
        if (r) begin
            m_locked = 1'b0; m_wait = 0;
            exp_out = 2'b00; exp_cid = 32'd0; exp_lrd = 32'd0;
        end else begin
            exp_out = {gc, gl};
            if (gc) exp_cid = rd;
            if (gl) exp_lrd = rd;
            m_wait   = (lr && !gl) ? ((m_wait < SMAX) ? m_wait + 1 : SMAX) : 0;
            m_locked = m_locked ? lh : (gl && lh);
        end
        @(posedge clk);
        #1;
        obs_out = {cpu_valid, ldr_valid};
        obs_cid = cpu_id;
        obs_lrd = ldr_rdata;
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if ({obs_out, obs_cid, obs_lrd} !== 66'd0) begin
            fails++;
            $display("FAIL reset_outputs: got valids=%b id=%h rdata=%h want all zero", obs_out, obs_cid, obs_lrd);
        end
    endtask

    task automatic test_cpu_fetch();
        tick(1'b0, 1'b1, 32'h8000_0008, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if (obs_ia !== 32'h0000_0008) begin
            fails++; $display("FAIL fetch_mem_ia: got %h want 00000008", obs_ia);
        end
        checks++;
        if (obs_comb !== 4'b1000) begin
            fails++; $display("FAIL fetch_ready: got %b want 1000", obs_comb);
        end
        checks++;
        if (obs_out !== 2'b10 || obs_cid !== mem[2]) begin
            fails++; $display("FAIL fetch_resp: got valids=%b id=%h want 10 id=%h", obs_out, obs_cid, mem[2]);
        end
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, rand_addr(), 1'b1, 1'b0, 1'b0, rand_addr(), 32'd0);
            checks++;
            if (obs_comb[3:2] !== ((i == 4) ? 2'b01 : 2'b10)) begin
                fails++;
                $display("FAIL starve_grant cyc %0d: got %b want %b", i, obs_comb[3:2], (i == 4) ? 2'b01 : 2'b10);
            end
            checks++;
            if (obs_ia !== exp_ia || obs_out !== exp_out || obs_cid !== exp_cid || obs_lrd !== exp_lrd) begin
                fails++;
                $display("FAIL starve_data cyc %0d: got ia=%h v=%b id=%h rd=%h want ia=%h v=%b id=%h rd=%h",
                         i, obs_ia, obs_out, obs_cid, obs_lrd, exp_ia, exp_out, exp_cid, exp_lrd);
            end
        end
    endtask

    task automatic test_loader_write();
        logic [31:0] old;
        old = mem[4];
        tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        checks++;
        if (obs_comb !== 4'b0101 || obs_ia !== 32'h10 || obs_wd !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL ldr_write_bus: got comb=%b ia=%h wd=%h want 0101 00000010 deadbeef", obs_comb, obs_ia, obs_wd);
        end
        checks++;
        if (obs_out !== 2'b01 || obs_lrd !== old) begin
            fails++; $display("FAIL ldr_write_ack: got v=%b rd=%h want 01 rd=%h", obs_out, obs_lrd, old);
        end
        tick(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if (obs_comb[0] !== 1'b0 || obs_out !== 2'b10 || obs_cid !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL readback: got we=%b v=%b id=%h want 0 10 deadbeef", obs_comb[0], obs_out, obs_cid);
        end
    endtask

    task automatic test_lock();
        tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h1111_0000);
        for (int i = 0; i < 4; i++) begin
            // three locked writes, then the hold-release cycle still owned by the loader
            tick(1'b0, 1'b1, 32'h4, 1'b1, 1'b1, (i < 3), 32'h24 + 32'(4 * i), 32'h2222_0000 + 32'(i));
            checks++;
            if (obs_comb !== 4'b0111 || obs_out !== 2'b01) begin
                fails++; $display("FAIL lock_cyc %0d: got comb=%b v=%b want 0111 01", i, obs_comb, obs_out);
            end
        end
        tick(1'b0, 1'b1, 32'h24, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if (obs_comb !== 4'b1000 || obs_cid !== 32'h2222_0000) begin
            fails++; $display("FAIL unlock_cpu: got comb=%b id=%h want 1000 22220000", obs_comb, obs_cid);
        end
    endtask

    task automatic test_reset_midway();
        tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'h8, 32'd0);
        tick(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        checks++;
        if ({obs_out, obs_cid, obs_lrd} !== 66'd0) begin
            fails++; $display("FAIL reset_mid: got v=%b id=%h rd=%h want zeros", obs_out, obs_cid, obs_lrd);
        end
        tick(1'b0, 1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 32'h8, 32'd0);
        checks++;
        if (obs_comb[3:2] !== 2'b10 || obs_out !== 2'b10 || obs_cid !== mem[3]) begin
            fails++;
            $display("FAIL after_reset_arb: got gnt=%b v=%b id=%h want 10 10 %h", obs_comb[3:2], obs_out, obs_cid, mem[3]);
        end
    endtask

    task automatic test_idle();
        logic [31:0] last;
        last = obs_cid;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, rand_addr(), 1'b0, 1'b1, 1'b0, rand_addr(), 32'd0);
            checks++;
            if (obs_comb !== 4'b0000 || obs_out !== 2'b00 || obs_cid !== last) begin
                fails++;
                $display("FAIL idle cyc %0d: got comb=%b v=%b id=%h want 0000 00 %h", i, obs_comb, obs_out, obs_cid, last);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), rand_addr(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 rand_addr(), $urandom());
            checks++;
            if (obs_comb !== exp_comb || obs_ia !== exp_ia) begin
                fails++;
                $display("FAIL rand_bus cyc %0d: got comb=%b ia=%h want comb=%b ia=%h", i, obs_comb, obs_ia, exp_comb, exp_ia);
            end
            checks++;
            if (obs_out !== exp_out || obs_cid !== exp_cid || obs_lrd !== exp_lrd) begin
                fails++;
                $display("FAIL rand_resp cyc %0d: got v=%b id=%h rd=%h want v=%b id=%h rd=%h",
                         i, obs_out, obs_cid, obs_lrd, exp_out, exp_cid, exp_lrd);
            end
        end
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_ia = 32'd0; ldr_req = 1'b0; ldr_we = 1'b0;
        ldr_hold = 1'b0; ldr_addr = 32'd0; ldr_wdata = 32'd0;
        m_locked = 1'b0; m_wait = 0;
        for (int i = 0; i < 64; i++) mem[i] <= $urandom();
        @(negedge clk);
        test_reset();
        test_cpu_fetch();
        test_starvation();
        test_loader_write();
        test_lock();
        test_reset_midway();
        test_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
